carrd_wb_arbiter: RTL and testbench

Parametrised writeback stage for the Carrd vector coprocessor. Each functional unit (VALU, VMUL, VLOAD, VSLDU, VRED) hands its result over a valid/ready channel, and each unit has its own small FIFO. A round-robin arbiter picks one buffered result per cycle and drives a single registered write port to the vector register file, the scalar (x) register file or the element-write port. This replaces the previous combinational opcode-priority mux, which silently dropped results when two units finished in the same cycle.

---
 rtl/carrd_wb_pkg.sv | 29 ++
 rtl/carrd_wb_fifo.sv | 66 ++++++
 rtl/carrd_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_carrd_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/carrd_wb_pkg.sv
// Shared types and constants for the Carrd writeback stage: destination
// encoding, functional-unit IDs and the default-width buffered result entry.
package carrd_wb_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_VREG = 2'b01,
    WB_XREG = 2'b10,
    WB_ELEM = 2'b11
  } wb_dest_e;

  localparam int unsigned UNIT_VALU  = 0;
  localparam int unsigned UNIT_VMUL  = 1;
  localparam int unsigned UNIT_VLOAD = 2;
  localparam int unsigned UNIT_VSLDU = 3;
  localparam int unsigned UNIT_VRED  = 4;

  localparam int unsigned WB_DEF_AW   = 5;
  localparam int unsigned WB_DEF_VLEN = 512;

  // Entry layout for the default configuration; the arbiter builds the same
  // layout from its own AW/VLEN parameters.
  typedef struct packed {
    wb_dest_e               dest;
    logic [WB_DEF_AW-1:0]   addr;
    logic [WB_DEF_VLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/carrd_wb_fifo.sv
// Per-unit result FIFO: power-of-2 depth, no push-through when full,
// synchronous flush that overrides push and pop.
module carrd_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PW bits wide, so +1 wraps modulo DEPTH.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/carrd_wb_arbiter.sv
// Writeback stage: per-unit result FIFOs, round-robin selection of one
// buffered result per cycle, and a registered register-file write port.
module carrd_wb_arbiter
  import carrd_wb_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 5,
  parameter int unsigned VLEN      = 512,
  parameter int unsigned LANE_W    = 128,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned AW        = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_UNITS-1:0]          res_valid,
  output logic [NUM_UNITS-1:0]          res_ready,
  input  logic [NUM_UNITS*2-1:0]        res_dest,
  input  logic [NUM_UNITS*AW-1:0]       res_addr,
  input  logic [NUM_UNITS*VLEN-1:0]     res_data,
  output logic                          v_reg_wr_en,
  output logic                          x_reg_wr_en,
  output logic                          el_wr_en,
  output logic [AW-1:0]                 wr_addr,
  output logic [AW-1:0]                 el_wr_addr,
  output logic [VLEN-1:0]               reg_wr_data,
  output logic [$clog2(NUM_UNITS)-1:0]  wb_unit,
  output logic                          busy
);

  localparam int unsigned UW        = $clog2(NUM_UNITS);
  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam int unsigned NUM_LANES = VLEN / LANE_W;

  typedef struct packed {
    wb_dest_e          dest;
    logic [AW-1:0]     addr;
    logic [VLEN-1:0]   data;
  } entry_t;

  entry_t                push_entry [NUM_UNITS];
  entry_t                pop_entry  [NUM_UNITS];
  logic [CW-1:0]         count      [NUM_UNITS];
  logic [NUM_UNITS-1:0]  full, empty, pop;

  logic                  gnt_valid;
  logic [UW-1:0]         gnt_idx;
  entry_t                gnt_entry;
  logic [VLEN-1:0]       zext_data;

  logic [UW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  v_en_q, v_en_d;
  logic                  x_en_q, x_en_d;
  logic                  el_en_q, el_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [AW-1:0]         el_addr_q, el_addr_d;
  logic [VLEN-1:0]       data_q, data_d;
  logic [UW-1:0]         unit_q, unit_d;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    assign push_entry[g] = {res_dest[g*2 +: 2], res_addr[g*AW +: AW], res_data[g*VLEN +: VLEN]};

    carrd_wb_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(entry_t))
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (res_valid[g] & ~full[g]),
      .push_data (push_entry[g]),
      .pop       (pop[g]),
      .pop_data  (pop_entry[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .count     (count[g])
    );
  end

  assign res_ready = ~full;

  // Scan from rr_ptr with wrap; the first non-empty FIFO wins.
  always_comb begin : arb
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pop       = '0;
    if (!flush) begin
      for (int unsigned off = 0; off < NUM_UNITS; off++) begin
        idx = 32'(rr_ptr_q) + off;
        if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
        if (!gnt_valid && !empty[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = UW'(idx);
        end
      end
    end
    if (gnt_valid) pop[gnt_idx] = 1'b1;

    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) rr_ptr_d = (gnt_idx == UW'(NUM_UNITS-1)) ? '0 : gnt_idx + UW'(1);
  end

  always_comb begin
    gnt_entry = pop_entry[gnt_idx];
    zext_data = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (k == 0) zext_data[k*LANE_W +: LANE_W] = LANE_W'(gnt_entry.data[XLEN-1:0]);
    end

    v_en_d    = 1'b0;
    x_en_d    = 1'b0;
    el_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    el_addr_d = el_addr_q;
    data_d    = data_q;
    unit_d    = unit_q;
    if (gnt_valid) begin
      case (gnt_entry.dest)
        WB_VREG: begin
          v_en_d    = 1'b1;
          wr_addr_d = gnt_entry.addr;
          data_d    = gnt_entry.data;
          unit_d    = gnt_idx;
        end
        WB_XREG: begin
          x_en_d    = 1'b1;
          wr_addr_d = gnt_entry.addr;
          data_d    = zext_data;
          unit_d    = gnt_idx;
        end
        WB_ELEM: begin
          el_en_d   = 1'b1;
          el_addr_d = gnt_entry.addr;
          data_d    = zext_data;
          unit_d    = gnt_idx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      v_en_q    <= 1'b0;
      x_en_q    <= 1'b0;
      el_en_q   <= 1'b0;
      wr_addr_q <= '0;
      el_addr_q <= '0;
      data_q    <= '0;
      unit_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      v_en_q    <= v_en_d;
      x_en_q    <= x_en_d;
      el_en_q   <= el_en_d;
      wr_addr_q <= wr_addr_d;
      el_addr_q <= el_addr_d;
      data_q    <= data_d;
      unit_q    <= unit_d;
    end
  end

  always_comb begin
    busy = v_en_q | x_en_q | el_en_q;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (count[i] != '0) busy = 1'b1;
    end
  end

  assign v_reg_wr_en = v_en_q;
  assign x_reg_wr_en = x_en_q;
  assign el_wr_en    = el_en_q;
  assign wr_addr     = wr_addr_q;
  assign el_wr_addr  = el_addr_q;
  assign reg_wr_data = data_q;
  assign wb_unit     = unit_q;

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// Directed bench for carrd_wb_arbiter with hand-computed expected writes.
module tb_carrd_wb_arbiter;
  import carrd_wb_pkg::*;

  localparam int unsigned NU   = 5;
  localparam int unsigned VLEN = 512;
  localparam int unsigned AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush = 1'b0;
  logic [NU-1:0]        res_valid = '0;
  logic [NU-1:0]        res_ready;
  logic [NU*2-1:0]      res_dest = '0;
  logic [NU*AW-1:0]     res_addr = '0;
  logic [NU*VLEN-1:0]   res_data = '0;
  logic                 v_reg_wr_en, x_reg_wr_en, el_wr_en;
  logic [AW-1:0]        wr_addr, el_wr_addr;
  logic [VLEN-1:0]      reg_wr_data;
  logic [2:0]           wb_unit;
  logic                 busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  carrd_wb_arbiter #(
    .NUM_UNITS (NU),
    .VLEN      (VLEN),
    .LANE_W    (128),
    .XLEN      (32),
    .DEPTH     (2),
    .AW        (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_dest    (res_dest),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .v_reg_wr_en (v_reg_wr_en),
    .x_reg_wr_en (x_reg_wr_en),
    .el_wr_en    (el_wr_en),
    .wr_addr     (wr_addr),
    .el_wr_addr  (el_wr_addr),
    .reg_wr_data (reg_wr_data),
    .wb_unit     (wb_unit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VLEN-1:0] mk(input logic [31:0] base);
    logic [VLEN-1:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = base + 32'(j);
    return r;
  endfunction

  task automatic drive(input int unsigned u, input logic v, input wb_dest_e d,
                       input logic [AW-1:0] a, input logic [VLEN-1:0] dat);
    res_valid[u]            = v;
    res_dest[u*2 +: 2]      = d;
    res_addr[u*AW +: AW]    = a;
    res_data[u*VLEN +: VLEN] = dat;
  endtask

  task automatic check_out(input string tag, input logic [2:0] strb, input int unsigned unit,
                           input logic [AW-1:0] wa, input logic [AW-1:0] ea, input logic [VLEN-1:0] dat);
    check({tag, ".strb"}, VLEN'({v_reg_wr_en, x_reg_wr_en, el_wr_en}), VLEN'(strb));
    check({tag, ".unit"}, VLEN'(wb_unit), VLEN'(unit));
    check({tag, ".wa"},   VLEN'(wr_addr), VLEN'(wa));
    check({tag, ".ea"},   VLEN'(el_wr_addr), VLEN'(ea));
    check({tag, ".data"}, reg_wr_data, dat);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".strb"}, VLEN'({v_reg_wr_en, x_reg_wr_en, el_wr_en}), '0);
  endtask

  // Streaming scenario script, one entry per edge: offered VALU/VLOAD item
  // (-1 = none), required ready before the edge, unit written after it (7 = none).
  int a_seq [10] = '{0, 1, 2, 3, 3, -1, -1, -1, -1, -1};
  int l_seq [10] = '{0, 1, 2, 2, 3, 3, -1, -1, -1, -1};
  int r0_seq[10] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1};
  int r2_seq[10] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1};
  int ou_seq[10] = '{7, 0, 2, 0, 2, 0, 2, 0, 2, 7};
  int ok_seq[10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] a5, tmp;
    int unsigned eu, ek;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check_out("rst", 3'b000, 0, 0, 0, '0);
    check("rst.busy", VLEN'(busy), '0);
    tick();
    tick();
    rst = 1'b0;
    check("rst.ready", VLEN'(res_ready), VLEN'(5'h1f));

    // Single VALU VREG result: two-cycle latency, one-cycle strobe
    a5 = {64{8'hA5}};
    drive(UNIT_VALU, 1'b1, WB_VREG, 5'd3, a5);
    tick();
    drive(UNIT_VALU, 1'b0, WB_NONE, '0, '0);
    check_idle("t1.lat");
    check("t1.busy", VLEN'(busy), VLEN'(1));
    tick();
    check_out("t1.wr", 3'b100, 0, 3, 0, a5);
    tick();
    check_out("t1.hold", 3'b000, 0, 3, 0, a5);
    check("t1.busy0", VLEN'(busy), '0);

    // VMUL and VSLDU on the same edge
    drive(UNIT_VMUL, 1'b1, WB_VREG, 5'd1, mk(32'h1000_0000));
    drive(UNIT_VSLDU, 1'b1, WB_VREG, 5'd9, mk(32'h3000_0000));
    tick();
    drive(UNIT_VMUL, 1'b0, WB_NONE, '0, '0);
    drive(UNIT_VSLDU, 1'b0, WB_NONE, '0, '0);
    check_idle("t2.lat");
    tick();
    check_out("t2.vmul", 3'b100, 1, 1, 0, mk(32'h1000_0000));
    tick();
    check_out("t2.vsldu", 3'b100, 3, 9, 0, mk(32'h3000_0000));
    tick();
    check_idle("t2.idle");

    // rr_ptr now 4: VRED (ELEM) wins over VALU
    tmp = mk(32'hDEAD_0000);
    tmp[31:0] = 32'h0000_0010;
    drive(UNIT_VALU, 1'b1, WB_VREG, 5'd2, mk(32'h0000_0100));
    drive(UNIT_VRED, 1'b1, WB_ELEM, 5'd0, tmp);
    tick();
    drive(UNIT_VALU, 1'b0, WB_NONE, '0, '0);
    drive(UNIT_VRED, 1'b0, WB_NONE, '0, '0);
    tick();
    check_out("t3.elem", 3'b001, 4, 9, 0, 512'h10);
    tick();
    check_out("t3.valu", 3'b100, 0, 2, 0, mk(32'h0000_0100));
    tmp = mk(32'hBEEF_0000);
    tmp[31:0] = 32'hCAFE_F00D;
    drive(UNIT_VRED, 1'b1, WB_XREG, 5'd7, tmp);
    tick();
    drive(UNIT_VRED, 1'b0, WB_NONE, '0, '0);
    check_idle("t3.gap");
    tick();
    check_out("t3.xreg", 3'b010, 4, 7, 0, 512'hCAFEF00D);
    tick();
    check_idle("t3.idle");

    // VLOAD streams four, VALU keeps requesting; rr_ptr starts at 0
    for (int s = 0; s < 10; s++) begin
      if (a_seq[s] >= 0) drive(UNIT_VALU, 1'b1, WB_VREG, 5'(10 + a_seq[s]), mk(32'hA000_0000 + 32'(a_seq[s] << 8)));
      else               drive(UNIT_VALU, 1'b0, WB_NONE, '0, '0);
      if (l_seq[s] >= 0) drive(UNIT_VLOAD, 1'b1, WB_VREG, 5'(20 + l_seq[s]), mk(32'hB000_0000 + 32'(l_seq[s] << 8)));
      else               drive(UNIT_VLOAD, 1'b0, WB_NONE, '0, '0);
      check($sformatf("t4.%0d.rdy0", s), VLEN'(res_ready[UNIT_VALU]), VLEN'(r0_seq[s]));
      check($sformatf("t4.%0d.rdy2", s), VLEN'(res_ready[UNIT_VLOAD]), VLEN'(r2_seq[s]));
      tick();
      if (ou_seq[s] == 7) begin
        check_idle($sformatf("t4.%0d.idle", s));
      end else begin
        eu = ou_seq[s];
        ek = ok_seq[s];
        check_out($sformatf("t4.%0d.wr", s), 3'b100, eu, 5'((eu == 0 ? 10 : 20) + ek), 0,
                  mk((eu == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(ek << 8)));
      end
    end
    drive(UNIT_VALU, 1'b0, WB_NONE, '0, '0);
    drive(UNIT_VLOAD, 1'b0, WB_NONE, '0, '0);
    check("t4.busy0", VLEN'(busy), '0);

    // Flush with two FIFOs holding data and a push on the flush edge; rr_ptr is 3
    drive(UNIT_VMUL, 1'b1, WB_VREG, 5'd4, mk(32'h5000_0000));
    drive(UNIT_VSLDU, 1'b1, WB_VREG, 5'd5, mk(32'h6000_0000));
    tick();
    drive(UNIT_VMUL, 1'b1, WB_VREG, 5'd14, mk(32'h5100_0000));
    drive(UNIT_VSLDU, 1'b1, WB_VREG, 5'd15, mk(32'h6100_0000));
    flush = 1'b1;
    check("t5.busy1", VLEN'(busy), VLEN'(1));
    tick();
    flush = 1'b0;
    drive(UNIT_VMUL, 1'b0, WB_NONE, '0, '0);
    drive(UNIT_VSLDU, 1'b0, WB_NONE, '0, '0);
    check_out("t5.flush", 3'b000, 2, 23, 0, mk(32'hB000_0300));
    check("t5.busy0", VLEN'(busy), '0);
    check("t5.ready", VLEN'(res_ready), VLEN'(5'h1f));
    tick();
    check_idle("t5.after");
    drive(UNIT_VALU, 1'b1, WB_VREG, 5'd6, mk(32'h7000_0000));
    drive(UNIT_VSLDU, 1'b1, WB_VREG, 5'd8, mk(32'h8000_0000));
    tick();
    drive(UNIT_VALU, 1'b0, WB_NONE, '0, '0);
    drive(UNIT_VSLDU, 1'b0, WB_NONE, '0, '0);
    tick();
    check_out("t5.rr3", 3'b100, 3, 8, 0, mk(32'h8000_0000));
    tick();
    check_out("t5.rr0", 3'b100, 0, 6, 0, mk(32'h7000_0000));

    // Asynchronous reset with three entries buffered; rr_ptr is 1
    drive(UNIT_VALU, 1'b1, WB_VREG, 5'd1, mk(32'h9000_0000));
    drive(UNIT_VMUL, 1'b1, WB_VREG, 5'd11, mk(32'h9100_0000));
    drive(UNIT_VLOAD, 1'b1, WB_VREG, 5'd12, mk(32'h9200_0000));
    drive(UNIT_VRED, 1'b1, WB_VREG, 5'd14, mk(32'h9400_0000));
    tick();
    res_valid = '0;
    tick();
    check_out("t6.pre", 3'b100, 1, 11, 0, mk(32'h9100_0000));
    #3 rst = 1'b1;
    #1;
    check_out("t6.rst", 3'b000, 0, 0, 0, '0);
    check("t6.busy", VLEN'(busy), '0);
    tick();
    #3 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle($sformatf("t6.post%0d", c));
      check($sformatf("t6.post%0d.busy", c), VLEN'(busy), '0);
    end
    drive(UNIT_VLOAD, 1'b1, WB_VREG, 5'd13, mk(32'h9900_0000));
    tick();
    drive(UNIT_VLOAD, 1'b0, WB_NONE, '0, '0);
    tick();
    check_out("t6.new", 3'b100, 2, 13, 0, mk(32'h9900_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
